// File: rtl/wb_master_biu_if.sv
// Core request/response and Wishbone B4 classic master signal bundle for wb_master_biu.
// The master modport is the BIU side; the slave modport is the core plus interconnect side.
interface wb_master_biu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SelWidth = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic [SelWidth-1:0]   sel_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;
  logic                  rty_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output adr_o, dat_o, we_o, cyc_o, stb_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  adr_o, dat_o, we_o, cyc_o, stb_o, sel_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wb_master_biu.sv
// Wishbone B4 classic master BIU: one load/store in flight, lane steering, load extension,
// misalignment rejection, bounded retry on rty_i and a per-attempt bus timeout.
module wb_master_biu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_master_biu_if.master bus
);
  localparam int unsigned OffWidth = $clog2(SEL_WIDTH);

  typedef enum logic [1:0] {StIdle, StBus, StRetry, StResp} state_e;

  state_e                r_state;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_we;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_req_we;
  logic [OffWidth-1:0]   r_off;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [3:0]            r_retry_cnt;
  logic [15:0]           r_tmo_cnt;

  logic [OffWidth-1:0]   w_req_off;
  logic [OffWidth-1:0]   w_size_mask;
  logic                  w_bad;
  logic [SEL_WIDTH-1:0]  w_sel_new;
  logic [DATA_WIDTH-1:0] w_dat_new;
  logic [DATA_WIDTH-1:0] w_rd_shift;
  logic [DATA_WIDTH-1:0] w_rd_mask;
  logic                  w_rd_sign;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_retry_ok;
  logic                  w_tmo_hit;

  assign w_req_off = bus.req_addr_i[OffWidth-1:0];

  // Request decode: alignment check, byte lanes and store data steering.
  always_comb begin
    w_size_mask = '0;
    for (int k = 0; k < int'(OffWidth); k++) begin
      if (k < (1 << bus.req_size_i) - 1 + 1 && k < int'(bus.req_size_i)) w_size_mask[k] = 1'b1;
    end
    w_bad = ({30'd0, bus.req_size_i} > OffWidth) || ((w_req_off & w_size_mask) != '0);
    w_sel_new = '0;
    for (int b = 0; b < int'(SEL_WIDTH); b++) begin
      if (b < (1 << bus.req_size_i)) w_sel_new[b] = 1'b1;
    end
    w_sel_new = w_sel_new << w_req_off;
    w_dat_new = bus.req_wdata_i << {w_req_off, 3'b000};
  end

  // Load path: move the addressed lanes to bit 0, then zero- or sign-extend.
  always_comb begin
    w_rd_shift = bus.dat_i >> {r_off, 3'b000};
    w_rd_mask  = '0;
    w_rd_sign  = 1'b0;
    for (int b = 0; b < int'(SEL_WIDTH); b++) begin
      if (b < (1 << r_size)) w_rd_mask[b*8 +: 8] = 8'hFF;
      if (b == (1 << r_size) - 1) w_rd_sign = ~r_uns & w_rd_shift[b*8 + 7];
    end
    w_rdata = (w_rd_shift & w_rd_mask) | (w_rd_sign ? ~w_rd_mask : '0);
  end

  assign w_retry_ok = {28'd0, r_retry_cnt} < MAX_RETRIES;
  assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && ({16'd0, r_tmo_cnt} == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= StIdle;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_req_we    <= 1'b0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_retry_cnt <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid_i && r_ready) begin
            r_ready <= 1'b0;
            if (w_bad) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state   <= StBus;
              r_adr     <= {bus.req_addr_i[ADDR_WIDTH-1:OffWidth], {OffWidth{1'b0}}};
              r_dat     <= w_dat_new;
              r_sel     <= w_sel_new;
              r_we      <= bus.req_we_i;
              r_req_we  <= bus.req_we_i;
              r_off     <= w_req_off;
              r_size    <= bus.req_size_i;
              r_uns     <= bus.req_unsigned_i;
              r_cyc     <= 1'b1;
              r_stb     <= 1'b1;
              r_tmo_cnt <= '0;
            end
          end
        end
        StBus: begin
          if (bus.ack_i || bus.err_i || (bus.rty_i && !w_retry_ok) || w_tmo_hit) begin
            r_state     <= StResp;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !bus.ack_i;
            r_rsp_rdata <= (bus.ack_i && !r_req_we) ? w_rdata : '0;
          end else if (bus.rty_i) begin
            r_state     <= StRetry;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_retry_cnt <= r_retry_cnt + 4'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        StRetry: begin
          // Address, data and lanes were held; only the strobes come back.
          r_state   <= StBus;
          r_cyc     <= 1'b1;
          r_stb     <= 1'b1;
          r_we      <= r_req_we;
          r_tmo_cnt <= '0;
        end
        StResp: begin
          r_state     <= StIdle;
          r_ready     <= 1'b1;
          r_retry_cnt <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.adr_o       = r_adr;
  assign bus.dat_o       = r_dat;
  assign bus.sel_o       = r_sel;
  assign bus.we_o        = r_we;
  assign bus.cyc_o       = r_cyc;
  assign bus.stb_o       = r_stb;
endmodule

// File: tb/tb_wb_master_biu.sv
// Directed bench for wb_master_biu: responses are checked against a queue of expected results
// pushed when each request is issued.
module tb_wb_master_biu;
  logic clk;
  logic rst_n;

  wb_master_biu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_master_biu #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .SEL_WIDTH     (4),
    .MAX_RETRIES   (2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_err = 0;
  string cur = "reset";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s.%s: observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any response the DUT produced.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (bus.rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {63'd0, bus.rsp_valid_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_err", {63'd0, bus.rsp_err_o}, {63'd0, e.err});
        chk("rsp_rdata", {32'd0, bus.rsp_rdata_o}, {32'd0, e.rdata});
      end
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic push,
                       input logic exp_err, input logic [31:0] exp_rdata);
    if (push) sb.push_back('{exp_err, exp_rdata});
    bus.req_valid_i    = 1'b1;
    bus.req_addr_i     = addr;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_wdata_i    = wdata;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic respond(input logic a, input logic e, input logic r, input logic [31:0] d);
    bus.ack_i = a;
    bus.err_i = e;
    bus.rty_i = r;
    bus.dat_i = d;
    step();
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
    bus.dat_i = '0;
  endtask

  task automatic load_ok(input string name, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] din, input logic [31:0] exp);
    cur = name;
    issue(addr, 1'b0, size, uns, 32'd0, 1'b1, 1'b0, exp);
    chk("stb", {63'd0, bus.stb_o}, 64'd1);
    respond(1'b1, 1'b0, 1'b0, din);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    step();
  endtask

  initial begin
    rst_n              = 1'b1;
    bus.req_valid_i    = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = '0;
    bus.req_unsigned_i = 1'b0;
    bus.req_wdata_i    = '0;
    bus.dat_i          = '0;
    bus.ack_i          = 1'b0;
    bus.err_i          = 1'b0;
    bus.rty_i          = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("cyc", {63'd0, bus.cyc_o}, 64'd0);
    chk("stb", {63'd0, bus.stb_o}, 64'd0);
    chk("we", {63'd0, bus.we_o}, 64'd0);
    chk("adr", {32'd0, bus.adr_o}, 64'd0);
    chk("dat", {32'd0, bus.dat_o}, 64'd0);
    chk("sel", {60'd0, bus.sel_o}, 64'd0);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("rsp_err", {63'd0, bus.rsp_err_o}, 64'd0);
    chk("rsp_rdata", {32'd0, bus.rsp_rdata_o}, 64'd0);
    rst_n = 1'b1;
    step();

    // Signed byte load from the top lane, zero-wait ack.
    cur = "lb_signed";
    issue(32'h103, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FF80);
    chk("cyc", {63'd0, bus.cyc_o}, 64'd1);
    chk("stb", {63'd0, bus.stb_o}, 64'd1);
    chk("sel", {60'd0, bus.sel_o}, 64'h8);
    chk("adr", {32'd0, bus.adr_o}, 64'h100);
    chk("we", {63'd0, bus.we_o}, 64'd0);
    chk("ready", {63'd0, bus.req_ready_o}, 64'd0);
    respond(1'b1, 1'b0, 1'b0, 32'h80FF_FF00);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    chk("cyc_drop", {63'd0, bus.cyc_o}, 64'd0);
    step();
    chk("ready_back", {63'd0, bus.req_ready_o}, 64'd1);
    chk("rsp_one_cycle", {63'd0, bus.rsp_valid_o}, 64'd0);

    // Half store to the upper lanes.
    cur = "sh";
    issue(32'h202, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0, 32'd0);
    chk("sel", {60'd0, bus.sel_o}, 64'hC);
    chk("dat_hi", {48'd0, bus.dat_o[31:16]}, 64'hBEEF);
    chk("we", {63'd0, bus.we_o}, 64'd1);
    chk("adr", {32'd0, bus.adr_o}, 64'h200);
    respond(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("we_drop", {63'd0, bus.we_o}, 64'd0);
    step();

    load_ok("lhu", 32'h106, 2'd1, 1'b1, 32'h9234_5678, 32'h0000_9234);
    load_ok("lh_signed", 32'h102, 2'd1, 1'b0, 32'hA5B6_0000, 32'hFFFF_A5B6);
    load_ok("lw", 32'h104, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_ok("lbu_lane1", 32'h101, 2'd0, 1'b1, 32'h1234_F600, 32'h0000_00F6);

    // Misaligned word and oversize dword: error with no bus cycle.
    cur = "misaligned";
    issue(32'h101, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
    chk("cyc", {63'd0, bus.cyc_o}, 64'd0);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    step();
    cur = "oversize";
    issue(32'h0, 1'b0, 2'd3, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
    chk("stb", {63'd0, bus.stb_o}, 64'd0);
    chk("rsp_err", {63'd0, bus.rsp_err_o}, 64'd1);
    step();

    // Two retries tolerated, then ack.
    cur = "retry_ok";
    issue(32'h300, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      respond(1'b0, 1'b0, 1'b1, 32'd0);
      chk("gap_cyc", {63'd0, bus.cyc_o}, 64'd0);
      step();
      chk("reissue_stb", {63'd0, bus.stb_o}, 64'd1);
      chk("reissue_adr", {32'd0, bus.adr_o}, 64'h300);
    end
    respond(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    step();

    // Third retry exhausts the budget.
    cur = "retry_fail";
    issue(32'h304, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 2; i++) begin
      respond(1'b0, 1'b0, 1'b1, 32'd0);
      step();
    end
    respond(1'b0, 1'b0, 1'b1, 32'd0);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    chk("cyc", {63'd0, bus.cyc_o}, 64'd0);
    step();

    // Silent slave: four strobe cycles then timeout error.
    cur = "timeout";
    issue(32'h400, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stb_held", {63'd0, bus.stb_o}, 64'd1);
      step();
    end
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    chk("rsp_err", {63'd0, bus.rsp_err_o}, 64'd1);
    chk("cyc", {63'd0, bus.cyc_o}, 64'd0);
    step();

    // ack wins over a simultaneous err.
    cur = "ack_err";
    issue(32'h500, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0BAD_F00D);
    respond(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    step();

    // Reset in the middle of a bus cycle: strobes drop at once, no response.
    cur = "reset_mid";
    issue(32'h600, 1'b1, 2'd2, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 32'd0);
    chk("stb_before", {63'd0, bus.stb_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("cyc", {63'd0, bus.cyc_o}, 64'd0);
    chk("stb", {63'd0, bus.stb_o}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("ready", {63'd0, bus.req_ready_o}, 64'd1);

    cur = "end";
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
